// File: rtl/exp3_gravador_sequencia_if.sv
// Write port of the stored-sequence memory: the recorder drives it (master),
// the memory array sits on the slave side.
interface exp3_gravador_sequencia_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dado;

    modport master (output mem_we, output mem_addr, output mem_dado);
    modport slave  (input  mem_we, input  mem_addr, input  mem_dado);
endinterface

// File: rtl/exp3_gravador_sequencia.sv
// Sequence recorder: after iniciar, each debounced-edge press on jogada stores
// chaves at the next memory address until all DEPTH entries are written.
module exp3_gravador_sequencia #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic                 jogada,
    input  logic [DATA_W-1:0]    chaves,
    exp3_gravador_sequencia_if.master mem,
    output logic                 pronto,
    output logic                 ocupado,
    output logic [ADDR_W-1:0]    db_contagem,
    output logic [3:0]           db_estado
);
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic [3:0] {
        INICIAL  = 4'h0,
        PREPARA  = 4'h1,
        ESPERA   = 4'h2,
        REGISTRA = 4'h3,
        GRAVA    = 4'h4,
        PROXIMO  = 4'h5,
        FIM      = 4'hF
    } estado_t;

    estado_t           estado, estado_prox;
    logic              s1, s2, s3;
    logic              jog_ed;
    logic [ADDR_W-1:0] contagem;
    logic [DATA_W-1:0] dado;
    logic              zera, registra, conta;

    // NOTE: non-blocking assignments make every flop sample the pre-edge value,
    // so the chain really delays by one clock per stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= jogada;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign jog_ed = s2 & ~s3;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= INICIAL;
        else        estado <= estado_prox;
    end

    // NOTE: every signal gets its default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        estado_prox = estado;
        zera        = 1'b0;
        registra    = 1'b0;
        conta       = 1'b0;
        case (estado)
            INICIAL:  if (iniciar) estado_prox = PREPARA;
            PREPARA: begin
                zera        = 1'b1;
                estado_prox = ESPERA;
            end
            ESPERA:   if (jog_ed) estado_prox = REGISTRA;
            REGISTRA: begin
                registra    = 1'b1;
                estado_prox = GRAVA;
            end
            GRAVA:    estado_prox = PROXIMO;
            PROXIMO: begin
                if (contagem == LAST) begin
                    estado_prox = FIM;
                end else begin
                    conta       = 1'b1;
                    estado_prox = ESPERA;
                end
            end
            FIM:      if (iniciar) estado_prox = PREPARA;
            default:  estado_prox = INICIAL;
        endcase
    end

    // Counter saturates at LAST: FIM is taken instead of incrementing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
            dado     <= '0;
        end else begin
            if (zera)       contagem <= '0;
            else if (conta) contagem <= contagem + 1'b1;
            if (zera)          dado <= '0;
            else if (registra) dado <= chaves;
        end
    end

    assign mem.mem_we   = (estado == GRAVA);
    assign mem.mem_addr = contagem;
    assign mem.mem_dado = dado;
    assign pronto       = (estado == FIM);
    assign ocupado      = (estado != INICIAL) && (estado != FIM);
    assign db_contagem  = contagem;
    assign db_estado    = estado;
endmodule

// File: tb/tb_exp3_gravador_sequencia.sv
// Self-checking bench for the sequence recorder: expected writes are queued by
// the stimulus side and checked by an independent write-port monitor.
module tb_exp3_gravador_sequencia;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;

    logic              clock   = 1'b0;
    logic              reset   = 1'b0;
    logic              iniciar = 1'b0;
    logic              jogada  = 1'b0;
    logic [DATA_W-1:0] chaves  = '0;
    logic              pronto, ocupado;
    logic [ADDR_W-1:0] db_contagem;
    logic [3:0]        db_estado;

    exp3_gravador_sequencia_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    exp3_gravador_sequencia #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .jogada      (jogada),
        .chaves      (chaves),
        .mem         (mem_if),
        .pronto      (pronto),
        .ocupado     (ocupado),
        .db_contagem (db_contagem),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dado;
    } wr_t;

    wr_t               exp_q[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] seen_mem  [DEPTH];
    bit                model_active = 1'b0;
    int                model_count  = 0;
    int                model_writes = 0;
    int                seen_writes  = 0;
    int                n_checks     = 0;
    int                n_fail       = 0;
    logic              prev_we      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write-port monitor: acts as the memory and compares against the queue.
    always @(negedge clock) begin : monitor
        wr_t e;
        if (mem_if.mem_we) begin
            check("we_single_cycle", prev_we, 0);
            seen_writes++;
            seen_mem[mem_if.mem_addr] = mem_if.mem_dado;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         mem_if.mem_addr, mem_if.mem_dado);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", mem_if.mem_addr, e.addr);
                check("wr_data", mem_if.mem_dado, e.dado);
            end
        end
        prev_we = mem_if.mem_we;
    end

    // Reference model: a press is recorded only while a sequence is open.
    task automatic accept(input logic [DATA_W-1:0] val);
        logic [ADDR_W-1:0] a;
        if (model_active && model_count < DEPTH) begin
            a = ADDR_W'(model_count);
            exp_q.push_back({a, val});
            model_mem[a] = val;
            model_count++;
            model_writes++;
        end
    endtask

    task automatic check_state(input string tag);
        bit         done;
        logic [3:0] exp_est;
        logic [3:0] exp_cnt;
        done    = model_active && (model_count == DEPTH);
        exp_est = !model_active ? 4'h0 : (done ? 4'hF : 4'h2);
        exp_cnt = done ? 4'hF : 4'(model_count);
        check({tag, "_estado"},   db_estado,   exp_est);
        check({tag, "_contagem"}, db_contagem, exp_cnt);
        check({tag, "_pronto"},   pronto,      done);
        check({tag, "_ocupado"},  ocupado,     model_active && !done);
    endtask

    task automatic press(input logic [DATA_W-1:0] val, input int hold);
        accept(val);
        @(negedge clock);
        chaves = val;
        jogada = 1'b1;
        repeat (hold) @(negedge clock);
        jogada = 1'b0;
        repeat (8) @(negedge clock);
        chaves = DATA_W'($urandom);
    endtask

    // Second edge lands while the first press is in REGISTRA/GRAVA.
    task automatic double_press(input logic [DATA_W-1:0] val);
        accept(val);
        @(negedge clock);
        chaves = val;
        jogada = 1'b1;
        @(negedge clock);
        jogada = 1'b0;
        @(negedge clock);
        jogada = 1'b1;
        @(negedge clock);
        jogada = 1'b0;
        repeat (10) @(negedge clock);
        chaves = DATA_W'($urandom);
    endtask

    task automatic pulse_iniciar();
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        if (!model_active || model_count == DEPTH) begin
            model_active = 1'b1;
            model_count  = 0;
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic random_fill();
        while (model_count < DEPTH) begin
            if ($urandom_range(0, 3) == 0) double_press(DATA_W'($urandom));
            else                           press(DATA_W'($urandom), $urandom_range(1, 6));
            check_state("fill");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;

        // Reset state
        repeat (3) @(negedge clock);
        check_state("reset");
        check("reset_we",   mem_if.mem_we,   0);
        check("reset_addr", mem_if.mem_addr, 0);
        check("reset_dado", mem_if.mem_dado, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_state("idle");

        // T1: reset in the middle of a write
        pulse_iniciar();
        check_state("t1_espera");
        @(negedge clock);
        chaves = 4'h9;
        jogada = 1'b1;
        @(negedge clock);
        jogada = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clock);
            #1;
            found = mem_if.mem_we;
        end
        check("t1_reach_grava", found, 1);
        reset = 1'b0;
        #1;
        model_active = 1'b0;
        model_count  = 0;
        check("t1_we",       mem_if.mem_we,   0);
        check("t1_estado",   db_estado,       0);
        check("t1_contagem", db_contagem,     0);
        check("t1_pronto",   pronto,          0);
        check("t1_dado",     mem_if.mem_dado, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_state("t1_after");

        // T2: full sequence with chaves = i ^ A
        pulse_iniciar();
        for (int i = 0; i < DEPTH; i++) begin
            press(4'(i) ^ 4'hA, 1);
            check_state("t2");
        end
        press(4'h3, 2);
        check_state("t2_fim_press");

        // T3: long press gives one write
        pulse_iniciar();
        press(DATA_W'($urandom), 50);
        check_state("t3");

        // T4: second edge while busy is dropped
        double_press(DATA_W'($urandom));
        check_state("t4");

        // T6: iniciar ignored in ESPERA
        while (model_count < 5) press(DATA_W'($urandom), $urandom_range(1, 4));
        for (int k = 0; k < 3; k++) pulse_iniciar();
        check_state("t6");

        random_fill();
        check_state("fim1");

        // T5: restart from FIM, colliding with a press edge
        @(negedge clock);
        jogada = 1'b1;
        @(negedge clock);
        jogada = 1'b0;
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check("t5_prepara", db_estado, 4'h1);
        check("t5_pronto",  pronto,    0);
        model_active = 1'b1;
        model_count  = 0;
        @(negedge clock);
        check_state("t5_espera");
        repeat (6) @(negedge clock);
        press(4'h7, 1);
        check_state("t5_first");

        random_fill();
        check_state("fim2");

        repeat (10) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);
        check("write_count", seen_writes, model_writes);
        for (int a = 0; a < DEPTH; a++) check("mem_content", seen_mem[a], model_mem[a]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
